instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch stage directly upstream of the 256x8 program ROM.
//  Drives ROM_ADDR and captures ROM_DATA, which has 1-cycle registered read latency.
//  Assembles 1- or 2-byte instructions (opcode [+ operand]) and hands each to the decoder
//  over a VALID/READY handshake. Accepts jump/branch/call redirects from the decoder.
// PARAMETERS
//  ADDR_WIDTH  8         ROM address width; PC and all address ports use this width
//  DATA_WIDTH  8         ROM word width; opcode and operand use this width
//  RESET_PC    8'h00     fetch address after reset
//  LONG_MASK   16'h02CF  bit n set => opcode[3:0]==n carries one operand byte
// PORTS
//  CLK            in   1   system clock; all state updates on rising edge
//  RESETn         in   1   asynchronous active-low reset
//  ROM_ADDR       out  8   address to ROM; equals internal fetch register FA
//  ROM_DATA       in   8   ROM output; holds ROM[ROM_ADDR of previous cycle]
//  INSTR_VALID    out  1   INSTR/OPERAND/INSTR_PC/NEXT_PC hold a complete instruction
//  INSTR_READY    in   1   decoder accepts; transfer occurs when VALID & READY at an edge
//  INSTR          out  8   opcode byte
//  OPERAND        out  8   operand byte; 8'h00 for 1-byte instructions
//  INSTR_PC       out  8   address of the opcode byte
//  NEXT_PC        out  8   INSTR_PC + instruction length, mod 256 (return address for calls)
//  REDIRECT       in   1   1-cycle pulse: restart fetch at REDIRECT_ADDR
//  REDIRECT_ADDR  in   8   target address; sampled only when REDIRECT=1
// BEHAVIOUR
//  Reset (async, RESETn=0): FA=RESET_PC, state=S_ISSUE, INSTR_VALID=0,
//   INSTR=OPERAND=INSTR_PC=NEXT_PC=0. Asserting reset mid-instruction drops all partial state.
//  FSM, all states registered; ROM_ADDR = FA in every state:
//   S_ISSUE     FA = opcode address; ROM latches at end of cycle          -> S_OP
//   S_OP        INSTR<=ROM_DATA, INSTR_PC<=FA, OPERAND<=0;
//               long = LONG_MASK[ROM_DATA[3:0]];
//               long: FA<=FA+1 -> S_ISSUE_ARG
//               else: NEXT_PC<=FA+1 -> S_VALID
//   S_ISSUE_ARG FA = operand address                                      -> S_ARG
//   S_ARG       OPERAND<=ROM_DATA, NEXT_PC<=FA+1                          -> S_VALID
//   S_VALID     INSTR_VALID=1; if INSTR_READY: FA<=NEXT_PC -> S_ISSUE; else hold
//  Latency: first S_ISSUE to VALID = 2 cycles (short) or 4 cycles (long).
//   Back-to-back with READY=1: 3 cycles/short instruction, 5 cycles/long instruction.
//  Stall: while VALID & !READY, all outputs and ROM_ADDR are held stable. VALID never drops
//   without a transfer, except on REDIRECT or reset.
//  REDIRECT (any state) has priority over the FSM.
//   Effect: FA<=REDIRECT_ADDR, state<=S_ISSUE, INSTR_VALID<=0 at the same edge.
//   Any partial instruction is discarded.
//   REDIRECT together with VALID&READY: the held instruction counts as transferred;
//   fetch resumes at REDIRECT_ADDR, not NEXT_PC.
//  Arithmetic: FA and NEXT_PC are ADDR_WIDTH-bit and wrap FF->00.
//   A long opcode at FF takes its operand from 00 and reports NEXT_PC=01.
//  INSTR_VALID is registered (decoded from state flop); no combinational path READY->VALID.
// TESTING
//  T1 reset release, ROM[00]=08 -> ROM_ADDR=00; VALID in 3rd cycle;
//     INSTR=08, OPERAND=00, INSTR_PC=00, NEXT_PC=01
//  T2 ROM[01]=07, ROM[02]=40, READY=1 -> INSTR=07, OPERAND=40, INSTR_PC=01, NEXT_PC=03;
//     4 cycles S_ISSUE->VALID; next fetch at 03
//  T3 READY=0 for 5 cycles in S_VALID -> VALID=1 and all outputs and ROM_ADDR constant;
//     single transfer when READY=1
//  T4 REDIRECT=1, REDIRECT_ADDR=80 during S_ARG -> no VALID for the interrupted instruction;
//     next INSTR_PC=80
//  T5 redirect to FF, ROM[FF]=00 (long), ROM[00]=12 -> INSTR=00, OPERAND=12, INSTR_PC=FF,
//     NEXT_PC=01
//  T6 RESETn low asynchronously in S_VALID -> VALID=0 and ROM_ADDR=RESET_PC before next edge;
//     refetch from RESET_PC after release

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Program counter and instruction-fetch stage in front of a
//                registered-read program ROM. Assembles 1- or 2-byte
//                instructions and offers them to the decoder over VALID/READY.
//                Accepts single-cycle fetch redirects from the decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [15:0]           LONG_MASK  = 16'h02CF
) (
   input  logic                  CLK,
   input  logic                  RESETn,
   output logic [ADDR_WIDTH-1:0] ROM_ADDR,
   input  logic [DATA_WIDTH-1:0] ROM_DATA,
   output logic                  INSTR_VALID,
   input  logic                  INSTR_READY,
   output logic [DATA_WIDTH-1:0] INSTR,
   output logic [DATA_WIDTH-1:0] OPERAND,
   output logic [ADDR_WIDTH-1:0] INSTR_PC,
   output logic [ADDR_WIDTH-1:0] NEXT_PC,
   input  logic                  REDIRECT,
   input  logic [ADDR_WIDTH-1:0] REDIRECT_ADDR
);

   localparam logic [2:0] S_ISSUE     = 3'd0;
   localparam logic [2:0] S_OP        = 3'd1;
   localparam logic [2:0] S_ISSUE_ARG = 3'd2;
   localparam logic [2:0] S_ARG       = 3'd3;
   localparam logic [2:0] S_VALID     = 3'd4;

   logic [2:0]            r_state;
   logic [2:0]            w_next_state;
   logic                  w_valid;
   logic [ADDR_WIDTH-1:0] r_fa;
   logic [ADDR_WIDTH-1:0] w_fa_inc;
   logic [DATA_WIDTH-1:0] r_instr;
   logic [DATA_WIDTH-1:0] r_operand;
   logic [ADDR_WIDTH-1:0] r_instr_pc;
   logic [ADDR_WIDTH-1:0] r_next_pc;
   logic                  w_long;

   // Fetch address increment wraps naturally at the address width.
   assign w_fa_inc = r_fa + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   // Opcode length lookup: low nibble of the byte currently presented by the ROM.
   assign w_long   = LONG_MASK[ROM_DATA[3:0]];

   // State register.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) r_state <= S_ISSUE;
      else         r_state <= w_next_state;
   end

   // Next-state logic; a redirect overrides whatever the sequence would do.
   always_comb begin
      w_next_state = r_state;
      if (REDIRECT) begin
         w_next_state = S_ISSUE;
      end else begin
         case (r_state)
            S_ISSUE:     w_next_state = S_OP;
            S_OP:        w_next_state = w_long ? S_ISSUE_ARG : S_VALID;
            S_ISSUE_ARG: w_next_state = S_ARG;
            S_ARG:       w_next_state = S_VALID;
            S_VALID:     w_next_state = INSTR_READY ? S_ISSUE : S_VALID;
            default:     w_next_state = S_ISSUE;
         endcase
      end
   end

   // VALID is a pure decode of the state flop, so READY never reaches it combinationally.
   always_comb begin
      w_valid = 1'b0;
      if (r_state == S_VALID) w_valid = 1'b1;
   end

   // Fetch address and instruction capture registers.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_fa       <= RESET_PC;
         r_instr    <= '0;
         r_operand  <= '0;
         r_instr_pc <= '0;
         r_next_pc  <= '0;
      end else if (REDIRECT) begin
         // Partial instruction is abandoned; the captured bytes are simply never offered.
         r_fa <= REDIRECT_ADDR;
      end else begin
         case (r_state)
            S_OP: begin
               r_instr    <= ROM_DATA;
               r_instr_pc <= r_fa;
               r_operand  <= '0;
               if (w_long) r_fa      <= w_fa_inc;
               else        r_next_pc <= w_fa_inc;
            end
            S_ARG: begin
               r_operand <= ROM_DATA;
               r_next_pc <= w_fa_inc;
            end
            S_VALID: begin
               if (INSTR_READY) r_fa <= r_next_pc;
            end
            default: ;
         endcase
      end
   end

   assign ROM_ADDR    = r_fa;
   assign INSTR_VALID = w_valid;
   assign INSTR       = r_instr;
   assign OPERAND     = r_operand;
   assign INSTR_PC    = r_instr_pc;
   assign NEXT_PC     = r_next_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit with a registered
//                ROM model and an instruction scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

   logic       CLK;
   logic       RESETn;
   logic [7:0] ROM_ADDR;
   logic [7:0] ROM_DATA;
   logic       INSTR_VALID;
   logic       INSTR_READY;
   logic [7:0] INSTR;
   logic [7:0] OPERAND;
   logic [7:0] INSTR_PC;
   logic [7:0] NEXT_PC;
   logic       REDIRECT;
   logic [7:0] REDIRECT_ADDR;

   logic [7:0]  rom [256];
   logic [15:0] long_mask;
   logic [31:0] sb [$];
   int          ts [$];
   int          cyc;
   int          total;
   int          bad;

   instr_fetch_unit dut (
      .CLK           (CLK),
      .RESETn        (RESETn),
      .ROM_ADDR      (ROM_ADDR),
      .ROM_DATA      (ROM_DATA),
      .INSTR_VALID   (INSTR_VALID),
      .INSTR_READY   (INSTR_READY),
      .INSTR         (INSTR),
      .OPERAND       (OPERAND),
      .INSTR_PC      (INSTR_PC),
      .NEXT_PC       (NEXT_PC),
      .REDIRECT      (REDIRECT),
      .REDIRECT_ADDR (REDIRECT_ADDR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ROM with one cycle of registered read latency.
   always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Architectural view of the instruction starting at pc.
   function automatic logic [31:0] model(input logic [7:0] pc);
      logic [7:0] op;
      logic [7:0] arg;
      logic [7:0] pc1;
      logic [7:0] npc;
      logic       lng;
      pc1 = pc + 8'd1;
      op  = rom[pc];
      lng = long_mask[op[3:0]];
      arg = lng ? rom[pc1] : 8'h00;
      npc = lng ? pc + 8'd2 : pc1;
      return {op, arg, pc, npc};
   endfunction

   // Scoreboard: every handshake must match the oldest expected instruction.
   always @(negedge CLK) begin
      if (RESETn && INSTR_VALID && INSTR_READY) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("sb_instr",   {24'd0, INSTR},    {24'd0, e[31:24]});
            chk("sb_operand", {24'd0, OPERAND},  {24'd0, e[23:16]});
            chk("sb_pc",      {24'd0, INSTR_PC}, {24'd0, e[15:8]});
            chk("sb_next_pc", {24'd0, NEXT_PC},  {24'd0, e[7:0]});
         end
         ts.push_back(cyc);
      end
   end

   // Call just after a rising edge with the DUT in S_ISSUE.
   task automatic wait_valid(input string tag, input int exp_n, input logic [7:0] exp_addr);
      int n;
      n = 0;
      @(negedge CLK);
      chk({tag, "_addr"}, {24'd0, ROM_ADDR}, {24'd0, exp_addr});
      while (!INSTR_VALID && n < 60) begin
         n++;
         @(negedge CLK);
      end
      chk({tag, "_cycles"}, n, exp_n);
   endtask

   // One-cycle READY pulse; call from a falling edge with VALID high.
   task automatic xfer();
      @(posedge CLK); #1 INSTR_READY = 1'b1;
      @(posedge CLK); #1 INSTR_READY = 1'b0;
   endtask

   task automatic redirect_to(input logic [7:0] a);
      @(posedge CLK); #1 REDIRECT = 1'b1; REDIRECT_ADDR = a;
      @(posedge CLK); #1 REDIRECT = 1'b0;
   endtask

   initial begin
      int k;
      total = 0; bad = 0; cyc = 0;
      long_mask = 16'h02CF;
      for (int i = 0; i < 256; i++) rom[i] = 8'h0B;
      rom[8'h00] = 8'h08; rom[8'h01] = 8'h07; rom[8'h02] = 8'h40;
      rom[8'h03] = 8'h05; rom[8'h04] = 8'h01; rom[8'h05] = 8'hAA;
      rom[8'h06] = 8'h0A; rom[8'h07] = 8'h09; rom[8'h08] = 8'h33;
      rom[8'h80] = 8'h06; rom[8'h81] = 8'h5C; rom[8'hFF] = 8'h00;
      RESETn = 1'b0; INSTR_READY = 1'b0; REDIRECT = 1'b0; REDIRECT_ADDR = 8'h00;

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_valid",   {31'd0, INSTR_VALID}, 32'd0);
      chk("rst_addr",    {24'd0, ROM_ADDR},    32'h00);
      chk("rst_instr",   {24'd0, INSTR},       32'h00);
      chk("rst_operand", {24'd0, OPERAND},     32'h00);
      chk("rst_pc",      {24'd0, INSTR_PC},    32'h00);
      chk("rst_next_pc", {24'd0, NEXT_PC},     32'h00);

      // T1: short opcode after reset, VALID in the third cycle
      @(posedge CLK); #1 RESETn = 1'b1;
      sb.push_back(model(8'h00));
      wait_valid("t1", 2, 8'h00);

      // T3: stall holds everything, then a single transfer
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("t3_valid",   {31'd0, INSTR_VALID}, 32'd1);
         chk("t3_instr",   {24'd0, INSTR},       32'h08);
         chk("t3_operand", {24'd0, OPERAND},     32'h00);
         chk("t3_pc",      {24'd0, INSTR_PC},    32'h00);
         chk("t3_next_pc", {24'd0, NEXT_PC},     32'h01);
         chk("t3_addr",    {24'd0, ROM_ADDR},    32'h00);
      end
      sb.push_back(model(8'h01));
      xfer();

      // T2: long opcode, four cycles to VALID
      wait_valid("t2", 4, 8'h01);
      xfer();

      // Back-to-back with READY held high: 3 cycles short, 5 cycles long
      sb.push_back(model(8'h03));
      sb.push_back(model(8'h04));
      sb.push_back(model(8'h06));
      sb.push_back(model(8'h07));
      ts.delete();
      INSTR_READY = 1'b1;
      k = 0;
      while (sb.size() > 0 && k < 100) begin
         @(negedge CLK);
         k++;
      end
      chk("b2b_drained", {31'd0, (sb.size() == 0)}, 32'd1);
      @(posedge CLK); #1 INSTR_READY = 1'b0;
      chk("b2b_count", ts.size(), 4);
      if (ts.size() == 4) begin
         chk("b2b_long_rate",  ts[1] - ts[0], 5);
         chk("b2b_short_rate", ts[2] - ts[1], 3);
         chk("b2b_long_rate2", ts[3] - ts[2], 5);
      end

      // Redirect while an unaccepted instruction (at 09) is valid
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
      chk("hold_pc",    {24'd0, INSTR_PC},    32'h09);
      redirect_to(8'h04);
      @(negedge CLK);
      chk("redir_valid", {31'd0, INSTR_VALID}, 32'd0);
      chk("redir_addr",  {24'd0, ROM_ADDR},    32'h04);

      // T4: redirect during S_ARG of the long instruction at 04
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("t4_arg_addr",  {24'd0, ROM_ADDR},    32'h05);
      chk("t4_arg_valid", {31'd0, INSTR_VALID}, 32'd0);
      REDIRECT = 1'b1; REDIRECT_ADDR = 8'h80;
      sb.push_back(model(8'h80));
      @(posedge CLK); #1 REDIRECT = 1'b0;
      wait_valid("t4", 4, 8'h80);

      // T5: redirect together with a transfer, long opcode at FF wraps
      rom[8'h00] = 8'h12;
      sb.push_back(model(8'hFF));
      @(posedge CLK); #1 INSTR_READY = 1'b1; REDIRECT = 1'b1; REDIRECT_ADDR = 8'hFF;
      @(posedge CLK); #1 INSTR_READY = 1'b0; REDIRECT = 1'b0;
      wait_valid("t5", 4, 8'hFF);
      chk("t5_arg_wrap_addr", {24'd0, ROM_ADDR}, 32'h00);
      xfer();

      // T6: asynchronous reset while valid
      wait_valid("t6", 4, 8'h01);
      chk("t6_instr", {24'd0, INSTR}, 32'h07);
      @(posedge CLK); #3 RESETn = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, INSTR_VALID}, 32'd0);
      chk("t6_rst_addr",  {24'd0, ROM_ADDR},    32'h00);
      chk("t6_rst_instr", {24'd0, INSTR},       32'h00);
      repeat (2) @(posedge CLK);
      #1 RESETn = 1'b1;
      sb.push_back(model(8'h00));
      wait_valid("t6_refetch", 4, 8'h00);
      xfer();

      @(negedge CLK);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
